// File: rtl/irq_controller_param.sv
// Parametrised interrupt controller: per-source edge/level pending, fixed or round-robin
// priority, and a single request to the host that is held until acked or withdrawn.
module irq_controller_param #(
    parameter int unsigned NUM_IRQ = 16,
    parameter int unsigned ID_W    = $clog2(NUM_IRQ),
    parameter int unsigned RR_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               cfg_we,
    input  logic [NUM_IRQ-1:0] cfg_mask,
    input  logic [NUM_IRQ-1:0] cfg_edge,
    output logic [NUM_IRQ-1:0] irq_mask,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    input  logic               ack_valid,
    input  logic [ID_W-1:0]    ack_id
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, edge_q, prev_q, pend_q, pend_d;
    logic [NUM_IRQ-1:0] eligible, rise, ack_clr;
    logic [ID_W-1:0]    id_q, id_d, rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    sel_id, sel_lo, sel_hi;
    logic               hit_hi;
    logic               out_q, out_d;
    logic               ack_ok;

    assign rise     = irq_lines & ~prev_q;
    assign eligible = pend_q & ~mask_q;
    assign ack_ok   = (state_q == StActive) && ack_valid && (ack_id == id_q);

    // Sticky edge bits: a new edge beats an ack clear in the same cycle.
    always_comb begin
        ack_clr = '0;
        if (ack_ok) begin
            ack_clr[id_q] = edge_q[id_q];
        end
        pend_d = (edge_q & (rise | (pend_q & ~ack_clr))) | (~edge_q & irq_lines);
        if (cfg_we) begin
            pend_d = pend_d & ~(edge_q & ~cfg_edge);
        end
    end

    // sel_lo: lowest eligible overall; sel_hi: lowest eligible at or above rr_ptr.
    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        hit_hi = 1'b0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_lo = ID_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    sel_hi = ID_W'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        sel_id = ((RR_MODE != 0) && hit_hi) ? sel_hi : sel_lo;
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        out_d    = out_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (eligible != '0) begin
                    id_d    = sel_id;
                    out_d   = 1'b1;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (ack_ok) begin
                    out_d    = 1'b0;
                    state_d  = StIdle;
                    rr_ptr_d = (id_q == ID_W'(NUM_IRQ - 1)) ? '0 : id_q + 1'b1;
                end else if (!eligible[id_q]) begin
                    // Withdraw: source masked or level dropped; no ack needed.
                    out_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '1;
            edge_q   <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            out_q    <= 1'b0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            state_q  <= StIdle;
        end else begin
            if (cfg_we) begin
                mask_q <= cfg_mask;
                edge_q <= cfg_edge;
            end
            prev_q   <= irq_lines;
            pend_q   <= pend_d;
            out_q    <= out_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= state_d;
        end
    end

    assign irq_mask    = mask_q;
    assign irq_pending = pend_q;
    assign irq_out     = out_q;
    assign irq_id      = id_q;

endmodule

// File: tb/tb_irq_controller_param.sv
// Vector-table bench for irq_controller_param: one fixed-priority and one round-robin
// instance share stimulus; each row names which instance it checks.
module tb_irq_controller_param;

    localparam int unsigned N = 16;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_lines, cfg_mask, cfg_edge;
    logic         cfg_we, ack_valid;
    logic [W-1:0] ack_id;
    logic [N-1:0] f_mask, f_pend, r_mask, r_pend;
    logic         f_out, r_out;
    logic [W-1:0] f_id, r_id;

    int errors = 0;
    int checks = 0;
    int n_fix;

    typedef struct {
        logic         rr;
        logic [N-1:0] lines;
        logic         we;
        logic [N-1:0] cmask;
        logic [N-1:0] cedge;
        logic         ackv;
        logic [W-1:0] ackid;
        logic         e_out;
        logic [W-1:0] e_id;
        logic [N-1:0] e_pend;
        logic [N-1:0] e_mask;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    irq_controller_param #(.NUM_IRQ(N), .RR_MODE(0)) u_dut_fix (
        .clk(clk), .rst_n(rst_n), .irq_lines(irq_lines), .cfg_we(cfg_we),
        .cfg_mask(cfg_mask), .cfg_edge(cfg_edge), .irq_mask(f_mask),
        .irq_pending(f_pend), .irq_out(f_out), .irq_id(f_id),
        .ack_valid(ack_valid), .ack_id(ack_id)
    );

    irq_controller_param #(.NUM_IRQ(N), .RR_MODE(1)) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .irq_lines(irq_lines), .cfg_we(cfg_we),
        .cfg_mask(cfg_mask), .cfg_edge(cfg_edge), .irq_mask(r_mask),
        .irq_pending(r_pend), .irq_out(r_out), .irq_id(r_id),
        .ack_valid(ack_valid), .ack_id(ack_id)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic rr, input logic [N-1:0] lines, input logic we,
                                input logic [N-1:0] cm, input logic [N-1:0] ce,
                                input logic av, input logic [W-1:0] ai, input logic eo,
                                input logic [W-1:0] ei, input logic [N-1:0] ep,
                                input logic [N-1:0] em);
        vec_t v;
        v.rr = rr;   v.lines = lines; v.we = we;     v.cmask = cm;  v.cedge = ce;
        v.ackv = av; v.ackid = ai;    v.e_out = eo;  v.e_id = ei;   v.e_pend = ep;
        v.e_mask = em;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        irq_lines = v.lines;
        cfg_we    = v.we;
        cfg_mask  = v.cmask;
        cfg_edge  = v.cedge;
        ack_valid = v.ackv;
        ack_id    = v.ackid;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.rr) begin
            chk("rr_out", idx, 64'(r_out), 64'(e.e_out));
            if (e.e_out) chk("rr_id", idx, 64'(r_id), 64'(e.e_id));
            chk("rr_pending", idx, 64'(r_pend), 64'(e.e_pend));
            chk("rr_mask", idx, 64'(r_mask), 64'(e.e_mask));
        end else begin
            chk("irq_out", idx, 64'(f_out), 64'(e.e_out));
            if (e.e_out) chk("irq_id", idx, 64'(f_id), 64'(e.e_id));
            chk("irq_pending", idx, 64'(f_pend), 64'(e.e_pend));
            chk("irq_mask", idx, 64'(f_mask), 64'(e.e_mask));
        end
    endtask

    initial begin
        irq_lines = '0; cfg_we = 1'b0; cfg_mask = '0; cfg_edge = '0;
        ack_valid = 1'b0; ack_id = '0;
        rst_n = 1'b0;

        // rr, lines, we, cmask, cedge, ackv, ackid | out, id, pending, mask
        // Level source 5: two-cycle latency, ack, re-assert after one idle cycle.
        add(0, 'h0000, 1, 'h0000, 'h0000, 0, 0,  0, 0, 'h0000, 'h0000);
        add(0, 'h0020, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0020, 'h0000);
        add(0, 'h0020, 0, 'h0000, 'h0000, 0, 0,  1, 5, 'h0020, 'h0000);
        add(0, 'h0020, 0, 'h0000, 'h0000, 1, 5,  0, 0, 'h0020, 'h0000);
        add(0, 'h0020, 0, 'h0000, 'h0000, 0, 0,  1, 5, 'h0020, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 1, 5,  0, 0, 'h0000, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0000, 'h0000);
        // Edge source 3: sticky after pulse, wrong-id ack ignored.
        add(0, 'h0000, 1, 'h0000, 'h0008, 0, 0,  0, 0, 'h0000, 'h0000);
        add(0, 'h0008, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0008, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  1, 3, 'h0008, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 1, 2,  1, 3, 'h0008, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 1, 3,  0, 0, 'h0000, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0000, 'h0000);
        // Fixed priority 2 before 7; late src 0 does not pre-empt 7.
        add(0, 'h0084, 1, 'h0000, 'h0000, 0, 0,  0, 0, 'h0084, 'h0000);
        add(0, 'h0084, 0, 'h0000, 'h0000, 0, 0,  1, 2, 'h0084, 'h0000);
        add(0, 'h0080, 0, 'h0000, 'h0000, 1, 2,  0, 0, 'h0080, 'h0000);
        add(0, 'h0080, 0, 'h0000, 'h0000, 0, 0,  1, 7, 'h0080, 'h0000);
        add(0, 'h0081, 0, 'h0000, 'h0000, 0, 0,  1, 7, 'h0081, 'h0000);
        add(0, 'h0081, 0, 'h0000, 'h0000, 0, 0,  1, 7, 'h0081, 'h0000);
        add(0, 'h0001, 0, 'h0000, 'h0000, 1, 7,  0, 0, 'h0001, 'h0000);
        add(0, 'h0001, 0, 'h0000, 'h0000, 0, 0,  1, 0, 'h0001, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 1, 0,  0, 0, 'h0000, 'h0000);
        // Edge on src 6 coincident with its ack: set wins, re-asserts.
        add(0, 'h0000, 1, 'h0000, 'h0040, 0, 0,  0, 0, 'h0000, 'h0000);
        add(0, 'h0040, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0040, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  1, 6, 'h0040, 'h0000);
        add(0, 'h0040, 0, 'h0000, 'h0000, 1, 6,  0, 0, 'h0040, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  1, 6, 'h0040, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 1, 6,  0, 0, 'h0000, 'h0000);
        // Mask active edge src 5: withdraw keeps sticky; idle ack ignored; unmask re-asserts.
        add(0, 'h0000, 1, 'h0000, 'h0020, 0, 0,  0, 0, 'h0000, 'h0000);
        add(0, 'h0020, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0020, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  1, 5, 'h0020, 'h0000);
        add(0, 'h0000, 1, 'h0020, 'h0020, 0, 0,  1, 5, 'h0020, 'h0020);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  0, 0, 'h0020, 'h0020);
        add(0, 'h0000, 0, 'h0000, 'h0000, 1, 5,  0, 0, 'h0020, 'h0020);
        add(0, 'h0000, 1, 'h0000, 'h0020, 0, 0,  0, 0, 'h0020, 'h0000);
        add(0, 'h0000, 0, 'h0000, 'h0000, 0, 0,  1, 5, 'h0020, 'h0000);
        n_fix = vecs.size();
        // Round-robin over level sources 1, 4, 9.
        add(1, 'h0212, 1, 'h0000, 'h0000, 0, 0,  0, 0, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 0, 0,  1, 1, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 1, 1,  0, 0, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 0, 0,  1, 4, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 1, 4,  0, 0, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 0, 0,  1, 9, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 1, 9,  0, 0, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 0, 0,  1, 1, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 1, 1,  0, 0, 'h0212, 'h0000);
        add(1, 'h0212, 0, 'h0000, 'h0000, 0, 0,  1, 4, 'h0212, 'h0000);

        repeat (2) @(negedge clk);
        chk("reset_out", -1, 64'(f_out), 64'(0));
        chk("reset_id", -1, 64'(f_id), 64'(0));
        chk("reset_pending", -1, 64'(f_pend), 64'(0));
        chk("reset_mask", -1, 64'(f_mask), 64'hffff);
        rst_n = 1'b1;

        for (int i = 0; i < n_fix; i++) apply(vecs[i], i);

        // Asynchronous reset while id 5 is active.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", -2, 64'(f_out), 64'(0));
        chk("async_rst_pending", -2, 64'(f_pend), 64'(0));
        chk("async_rst_mask", -2, 64'(f_mask), 64'hffff);
        irq_lines = '0; cfg_we = 1'b0; ack_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = n_fix; i < vecs.size(); i++) apply(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
